// File: rtl/bitonic_topk_pipe.sv
// rtl/bitonic_topk_pipe.sv - pipelined bitonic sorter returning the first K elements, valid/ready flow control
//
// Optional feature macro: BITONIC_IDX_EN (lane-index tags, index tie-break, idx_o port).
//
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset
//   valid_i  input vector valid            ready_o  input accepted this cycle when valid_i is high
//   desc_i   1 = descending, 0 = ascending (carried with the vector)
//   x_i      DATALENGTH unsigned elements, element 0 at index 0
//   valid_o  output vector valid           ready_i  downstream accepts
//   y_o      first TOPK elements in the selected order
//   idx_o    original lane of each y_o element (BITONIC_IDX_EN only)
//   busy_o   at least one vector in flight

module bitonic_topk_pipe #(
  parameter int DATAWIDTH  = 8,
  parameter int DATALENGTH = 16,
  parameter int TOPK       = 4,
  parameter int IDXWIDTH   = $clog2(DATALENGTH)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 desc_i,
  input  logic [DATAWIDTH-1:0] x_i [DATALENGTH],
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DATAWIDTH-1:0] y_o [TOPK],
`ifdef BITONIC_IDX_EN
  output logic [IDXWIDTH-1:0]  idx_o [TOPK],
`endif
  output logic                 busy_o
);

  localparam int N  = DATALENGTH;
  localparam int DW = DATAWIDTH;
  localparam int IW = IDXWIDTH;
  localparam int M  = $clog2(N);
  localparam int S  = M * (M + 1) / 2;

  // st_* are the registers behind each layer; lay_* are the layer results feeding them.
  logic [S-1:0]  st_vld;
  logic [S-1:0]  lay_vld;
  logic          st_dir   [S];
  logic          lay_dir  [S];
  logic [DW-1:0] st_data  [S][N];
  logic [DW-1:0] lay_data [S][N];
`ifdef BITONIC_IDX_EN
  logic [IW-1:0] st_tag   [S][N];
  logic [IW-1:0] lay_tag  [S][N];
`endif

  // prec(a, b): a belongs strictly before b in the final order selected by desc.
`ifdef BITONIC_IDX_EN
  function automatic logic prec(input logic desc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [IW-1:0] ta, input logic [IW-1:0] tb);
    if (a == b) return ta < tb;
    return desc ? (a > b) : (a < b);
  endfunction
`else
  function automatic logic prec(input logic desc, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return desc ? (a > b) : (a < b);
  endfunction
`endif

  logic adv;
  assign adv     = ~valid_o | ready_i;
  assign ready_o = adv;
  assign valid_o = st_vld[S-1];
  assign busy_o  = |st_vld;

  for (genvar p = 1; p <= M; p++) begin : g_phase
    for (genvar q = 1; q <= p; q++) begin : g_layer
      localparam int L = p * (p - 1) / 2 + q - 1;
      localparam int K = 1 << p;
      localparam int J = 1 << (p - q);

      logic [DW-1:0] src_d [N];
      logic          src_vld;
      logic          src_dir;
`ifdef BITONIC_IDX_EN
      logic [IW-1:0] src_t [N];
`endif

      if (L == 0) begin : g_src_in
        assign src_d   = x_i;
        assign src_vld = valid_i;
        assign src_dir = desc_i;
`ifdef BITONIC_IDX_EN
        for (genvar i = 0; i < N; i++) begin : g_tag_init
          assign src_t[i] = IW'(i);
        end
`endif
      end else begin : g_src_reg
        assign src_d   = st_data[L-1];
        assign src_vld = st_vld[L-1];
        assign src_dir = st_dir[L-1];
`ifdef BITONIC_IDX_EN
        assign src_t   = st_tag[L-1];
`endif
      end

      assign lay_vld[L] = src_vld;
      assign lay_dir[L] = src_dir;

      for (genvar i = 0; i < N; i++) begin : g_lane
        localparam int LO = i & ~J;
        localparam int HI = LO | J;
        // Blocks of size K alternate direction so each phase yields bitonic halves;
        // in the last phase every block runs in the final direction.
        localparam bit UP = ((LO & K) == 0);
        logic swap;
        if (UP) begin : g_up
`ifdef BITONIC_IDX_EN
          assign swap = prec(src_dir, src_d[HI], src_d[LO], src_t[HI], src_t[LO]);
`else
          assign swap = prec(src_dir, src_d[HI], src_d[LO]);
`endif
        end else begin : g_dn
`ifdef BITONIC_IDX_EN
          assign swap = prec(src_dir, src_d[LO], src_d[HI], src_t[LO], src_t[HI]);
`else
          assign swap = prec(src_dir, src_d[LO], src_d[HI]);
`endif
        end
        assign lay_data[L][i] = swap ? src_d[i ^ J] : src_d[i];
`ifdef BITONIC_IDX_EN
        assign lay_tag[L][i]  = swap ? src_t[i ^ J] : src_t[i];
`endif
      end
    end
  end

  // Single global enable: the whole pipe shifts or the whole pipe holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_vld <= '0;
      for (int s = 0; s < S; s++) begin
        st_dir[s] <= 1'b0;
        for (int i = 0; i < N; i++) begin
          st_data[s][i] <= '0;
`ifdef BITONIC_IDX_EN
          st_tag[s][i]  <= '0;
`endif
        end
      end
    end else if (adv) begin
      st_vld  <= lay_vld;
      st_dir  <= lay_dir;
      st_data <= lay_data;
`ifdef BITONIC_IDX_EN
      st_tag  <= lay_tag;
`endif
    end
  end

  for (genvar k = 0; k < TOPK; k++) begin : g_out
    assign y_o[k]   = st_data[S-1][k];
`ifdef BITONIC_IDX_EN
    assign idx_o[k] = st_tag[S-1][k];
`endif
  end

endmodule

// File: tb/tb_bitonic_topk_pipe.sv
// tb/tb_bitonic_topk_pipe.sv - scoreboard bench for bitonic_topk_pipe (N=16, K=4)

module tb_bitonic_topk_pipe;

  localparam int DW = 8;
  localparam int N  = 16;
  localparam int K  = 4;
  localparam int IW = $clog2(N);
  localparam int M  = $clog2(N);
  localparam int S  = M * (M + 1) / 2;

  logic          clk = 1'b0;
  logic          rst_i, valid_i, ready_o, desc_i, valid_o, ready_i, busy_o;
  logic [DW-1:0] x_i [N];
  logic [DW-1:0] y_o [K];
`ifdef BITONIC_IDX_EN
  logic [IW-1:0] idx_o [K];
`endif

  always #5 clk = ~clk;

  bitonic_topk_pipe #(.DATAWIDTH(DW), .DATALENGTH(N), .TOPK(K)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .desc_i  (desc_i),
    .x_i     (x_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .y_o     (y_o),
`ifdef BITONIC_IDX_EN
    .idx_o   (idx_o),
`endif
    .busy_o  (busy_o)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [K*DW-1:0] q_y   [$];
  logic [K*IW-1:0] q_idx [$];
  bit              hold_prev = 0;
  logic [K*DW-1:0] hold_y;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [K*DW-1:0] pack_y();
    logic [K*DW-1:0] r;
    for (int k = 0; k < K; k++) r[k*DW +: DW] = y_o[k];
    return r;
  endfunction

`ifdef BITONIC_IDX_EN
  function automatic logic [K*IW-1:0] pack_idx();
    logic [K*IW-1:0] r;
    for (int k = 0; k < K; k++) r[k*IW +: IW] = idx_o[k];
    return r;
  endfunction
`endif

  // Reference: stable insertion sort from lane order, so ties keep the lower lane first.
  function automatic void model(input logic [DW-1:0] x [N], input logic d,
                                output logic [K*DW-1:0] ey, output logic [K*IW-1:0] ei);
    logic [DW-1:0] v [N];
    logic [IW-1:0] t [N];
    logic [DW-1:0] tv;
    logic [IW-1:0] tt;
    for (int i = 0; i < N; i++) begin
      v[i] = x[i];
      t[i] = IW'(i);
    end
    for (int i = 1; i < N; i++) begin
      for (int j = i; j > 0; j--) begin
        if (d ? (v[j] > v[j-1]) : (v[j] < v[j-1])) begin
          tv = v[j]; v[j] = v[j-1]; v[j-1] = tv;
          tt = t[j]; t[j] = t[j-1]; t[j-1] = tt;
        end
      end
    end
    for (int k = 0; k < K; k++) begin
      ey[k*DW +: DW] = v[k];
      ei[k*IW +: IW] = t[k];
    end
  endfunction

  // Called at a falling edge with inputs already driven; returns whether the input was taken.
  task automatic tick(output bit acc);
    logic [K*DW-1:0] ey;
    logic [K*IW-1:0] ei;
    #1;
    if (hold_prev) begin
      chk("hold_valid", valid_o, 1'b1);
      chk("hold_y", pack_y(), hold_y);
    end
    if (!rst_i && valid_o && ready_i) begin
      if (q_y.size() == 0) begin
        chk("unexpected_out", valid_o, 1'b0);
      end else begin
        ey = q_y.pop_front();
        ei = q_idx.pop_front();
        chk("out_y", pack_y(), ey);
`ifdef BITONIC_IDX_EN
        chk("out_idx", pack_idx(), ei);
`endif
      end
    end
    acc = !rst_i && valid_i && ready_o;
    if (acc) begin
      model(x_i, desc_i, ey, ei);
      q_y.push_back(ey);
      q_idx.push_back(ei);
    end
    hold_prev = !rst_i && valid_o && !ready_i;
    hold_y    = pack_y();
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int w;
    int accepted;

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; desc_i = 1'b0;
    for (int i = 0; i < N; i++) x_i[i] = '0;
    @(negedge clk);
    tick(a);
    tick(a);
    rst_i = 1'b0;

    // Reset state
    chk("rst_valid_o", valid_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_ready_o", ready_o, 1'b1);
    chk("rst_y_o", pack_y(), '0);
`ifdef BITONIC_IDX_EN
    chk("rst_idx_o", pack_idx(), '0);
`endif

    // Ascending ramp sorted descending, exact latency and single-cycle pulse
    for (int i = 0; i < N; i++) x_i[i] = DW'(i);
    desc_i = 1'b1; valid_i = 1'b1;
    tick(a);
    chk("t1_accept", a, 1'b1);
    valid_i = 1'b0;
    for (int c = 1; c <= S + 2; c++) begin
      chk("t1_lat", valid_o, c == S);
      if (c == S) begin
        chk("t1_y", pack_y(), {8'd12, 8'd13, 8'd14, 8'd15});
`ifdef BITONIC_IDX_EN
        chk("t1_idx", pack_idx(), {4'd12, 4'd13, 4'd14, 4'd15});
`endif
      end
      tick(a);
    end

    // Back-to-back vectors with opposite directions
    for (int i = 0; i < N; i++) x_i[i] = DW'(15 - i);
    desc_i = 1'b0; valid_i = 1'b1;
    tick(a);
    for (int i = 0; i < N; i++) x_i[i] = 8'h80;
    desc_i = 1'b1;
    tick(a);
    valid_i = 1'b0;
    for (int c = 1; c <= S + 2; c++) begin
      chk("t2_valid", valid_o, (c == S - 1) || (c == S));
      if (c == S - 1) chk("t2_a_y", pack_y(), {8'd3, 8'd2, 8'd1, 8'd0});
      if (c == S) begin
        chk("t2_b_y", pack_y(), {8'h80, 8'h80, 8'h80, 8'h80});
`ifdef BITONIC_IDX_EN
        chk("t2_b_idx", pack_idx(), {4'd3, 4'd2, 4'd1, 4'd0});
`endif
      end
      tick(a);
    end

    // Ties, descending
    for (int i = 0; i < N; i++) x_i[i] = (i % 2 == 1) ? 8'd3 : 8'd7;
    desc_i = 1'b1; valid_i = 1'b1;
    tick(a);
    valid_i = 1'b0;
    for (int c = 1; c <= S + 1; c++) begin
      if (c == S) begin
        chk("tie_valid", valid_o, 1'b1);
        chk("tie_y", pack_y(), {8'd7, 8'd7, 8'd7, 8'd7});
`ifdef BITONIC_IDX_EN
        chk("tie_idx", pack_idx(), {4'd6, 4'd4, 4'd2, 4'd0});
`endif
      end
      tick(a);
    end

    // Backpressure: ready_i low from the start, pipe fills until the head reaches the output
    ready_i = 1'b0;
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < N; i++) x_i[i] = DW'($urandom);
      desc_i = v[0]; valid_i = 1'b1;
      tick(a);
      chk("bp_accept", a, 1'b1);
    end
    valid_i = 1'b0;
    w = 0;
    while (!valid_o && w < 40) begin
      tick(a);
      w++;
    end
    chk("bp_valid_rise", valid_o, 1'b1);
    for (int i = 0; i < N; i++) x_i[i] = DW'($urandom);
    desc_i = 1'b0; valid_i = 1'b1;
    for (int c = 0; c < 7; c++) begin
      chk("bp_ready_low", ready_o, 1'b0);
      tick(a);
      chk("bp_no_accept", a, 1'b0);
    end
    ready_i = 1'b1;
    tick(a);
    chk("bp_late_accept", a, 1'b1);
    valid_i = 1'b0;
    for (int c = 0; c < S + 8; c++) tick(a);
    chk("bp_drained", q_y.size(), 0);
    chk("bp_idle", busy_o, 1'b0);

    // Reset with vectors in flight
    ready_i = 1'b1;
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < N; i++) x_i[i] = DW'($urandom);
      desc_i = v[0]; valid_i = 1'b1;
      tick(a);
    end
    valid_i = 1'b0;
    rst_i = 1'b1;
    tick(a);
    rst_i = 1'b0;
    q_y.delete();
    q_idx.delete();
    chk("mrst_busy", busy_o, 1'b0);
    chk("mrst_ready", ready_o, 1'b1);
    for (int c = 0; c < S + 2; c++) begin
      chk("mrst_quiet", valid_o, 1'b0);
      tick(a);
    end

    // Random traffic with random backpressure; source holds a vector until taken
    accepted = 0;
    a = 1'b0;
    valid_i = 1'b0;
    for (int c = 0; c < 4000 && accepted < 300; c++) begin
      if (!valid_i || a) begin
        valid_i = ($urandom_range(0, 3) != 0);
        desc_i  = $urandom_range(0, 1);
        for (int i = 0; i < N; i++)
          x_i[i] = ($urandom_range(0, 1) == 1) ? DW'($urandom) : DW'($urandom_range(0, 3));
      end
      ready_i = ($urandom_range(0, 3) != 0);
      tick(a);
      if (a) accepted++;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int c = 0; c < S + 4; c++) tick(a);
    chk("rand_count", accepted, 300);
    chk("rand_drained", q_y.size(), 0);
    chk("rand_idle", busy_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
